// File: rtl/ddr4_ca_lane_ctrl_pkg.sv
// Shared types and constants for the DDR4 CA lane controller.
package ddr4_ca_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_MOVE,
    ST_GAP,
    ST_DONE
  } dly_state_e;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  // Width of a lane-select field; a single-lane build still needs one bit.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr4_ca_lane_ctrl_if.sv
// Delay-tap request/completion handshake between the command scheduler and the CA controller.
interface ddr4_ca_lane_ctrl_if #(
  parameter int NUM_LANES = 2,
  parameter int TAP_W     = 8
);
  import ddr4_ca_pkg::*;

  localparam int LANE_W = lane_w(NUM_LANES);

  logic              DLY_REQ_VALID;
  logic              DLY_REQ_READY;
  logic [LANE_W-1:0] DLY_REQ_LANE;
  logic [TAP_W-1:0]  DLY_REQ_TAP;
  logic              DLY_REQ_LOAD;
  logic              DLY_DONE;
  logic              DLY_ERR;

  modport master (
    output DLY_REQ_VALID, DLY_REQ_LANE, DLY_REQ_TAP, DLY_REQ_LOAD,
    input  DLY_REQ_READY, DLY_DONE, DLY_ERR
  );

  modport slave (
    input  DLY_REQ_VALID, DLY_REQ_LANE, DLY_REQ_TAP, DLY_REQ_LOAD,
    output DLY_REQ_READY, DLY_DONE, DLY_ERR
  );

endinterface

// File: rtl/ddr4_ca_lane_ctrl_tx_pipe.sv
// Fixed-latency register chain feeding the IOD TX/OE/PAR ports.
module ddr4_ca_tx_pipe #(
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [LAT-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[LAT-1];

endmodule

// File: rtl/ddr4_ca_lane_ctrl.sv
// DDR4 CA lane controller: TX/OE staging into 4:1 IODs plus a per-lane delay tap sequencer.
// Define DDR4_CA_PARITY_EN to add the PAR_TX_DATA output for the PAR pin IOD.
module ddr4_ca_lane_ctrl
  import ddr4_ca_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int SER_RATIO = 4,
  parameter int TAP_W     = 8,
  parameter int MAX_TAP   = 255,
  parameter int INIT_TAP  = 1,
  parameter int MOVE_GAP  = 2,
  parameter int TX_LAT    = 1
) (
  input  logic                           FAB_CLK,
  input  logic                           TX_SYNC_RST,
  input  logic [NUM_LANES*SER_RATIO-1:0] CMD_TX_DATA,
  input  logic [NUM_LANES*SER_RATIO-1:0] CMD_OE,
  output logic [NUM_LANES*SER_RATIO-1:0] TX_DATA,
  output logic [NUM_LANES*SER_RATIO-1:0] OE_DATA,
  ddr4_ca_lane_ctrl_if.slave             dly,
  output logic [NUM_LANES*TAP_W-1:0]     DLY_TAP,
  output logic [NUM_LANES-1:0]           DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]           DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]           DELAY_LINE_DIRECTION,
  input  logic [NUM_LANES-1:0]           DELAY_LINE_OUT_OF_RANGE
`ifdef DDR4_CA_PARITY_EN
  ,
  output logic [SER_RATIO-1:0]           PAR_TX_DATA
`endif
);

  localparam int                LANE_W = lane_w(NUM_LANES);
  localparam int                GAP_W  = $clog2(MOVE_GAP + 1);
  localparam logic [TAP_W:0]    MAX_T  = (TAP_W+1)'(MAX_TAP);
  localparam logic [TAP_W-1:0]  INIT_T = TAP_W'(INIT_TAP);

  ddr4_ca_tx_pipe #(.WIDTH(NUM_LANES*SER_RATIO), .LAT(TX_LAT)) u_data_pipe (
    .clk(FAB_CLK), .rst(TX_SYNC_RST), .d(CMD_TX_DATA), .q(TX_DATA)
  );

  ddr4_ca_tx_pipe #(.WIDTH(NUM_LANES*SER_RATIO), .LAT(TX_LAT)) u_oe_pipe (
    .clk(FAB_CLK), .rst(TX_SYNC_RST), .d(CMD_OE), .q(OE_DATA)
  );

`ifdef DDR4_CA_PARITY_EN
  logic [SER_RATIO-1:0] par_d;

  always_comb begin
    par_d = '0;
    for (int l = 0; l < NUM_LANES; l++) par_d ^= CMD_TX_DATA[l*SER_RATIO +: SER_RATIO];
  end

  ddr4_ca_tx_pipe #(.WIDTH(SER_RATIO), .LAT(TX_LAT)) u_par_pipe (
    .clk(FAB_CLK), .rst(TX_SYNC_RST), .d(par_d), .q(PAR_TX_DATA)
  );
`endif

  dly_state_e                      state;
  logic [NUM_LANES-1:0][TAP_W-1:0] tap;
  logic [LANE_W-1:0]               lane_q;
  logic [TAP_W-1:0]                tgt_q;
  logic [GAP_W-1:0]                gap_cnt;
  logic                            ready_q, done_q, err_q;
  logic [NUM_LANES-1:0]            load_q, move_q, dir_q;
  logic [TAP_W-1:0]                req_cur;

  assign req_cur = tap[dly.DLY_REQ_LANE];

  // Strobes are registered alongside the state: each transition loads the outputs of the state it enters.
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state   <= ST_IDLE;
      lane_q  <= '0;
      tgt_q   <= '0;
      gap_cnt <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= '0;
      move_q  <= '0;
      dir_q   <= '0;
      for (int l = 0; l < NUM_LANES; l++) tap[l] <= INIT_T;
    end else begin
      load_q <= '0;
      move_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dly.DLY_REQ_VALID) begin
            lane_q  <= dly.DLY_REQ_LANE;
            tgt_q   <= dly.DLY_REQ_TAP;
            ready_q <= 1'b0;
            if ({1'b0, dly.DLY_REQ_TAP} > MAX_T) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (dly.DLY_REQ_LOAD) begin
              state                      <= ST_LOAD;
              load_q[dly.DLY_REQ_LANE]   <= 1'b1;
            end else if (dly.DLY_REQ_TAP == req_cur) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state                    <= ST_SETUP;
              dir_q                    <= '0;
              dir_q[dly.DLY_REQ_LANE]  <= (dly.DLY_REQ_TAP > req_cur) ? DIR_INC : DIR_DEC;
            end
          end
        end
        ST_LOAD: begin
          tap[lane_q] <= INIT_T;
          if (tgt_q == INIT_T) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            state         <= ST_SETUP;
            dir_q         <= '0;
            dir_q[lane_q] <= (tgt_q > INIT_T) ? DIR_INC : DIR_DEC;
          end
        end
        ST_SETUP: begin
          state          <= ST_MOVE;
          move_q[lane_q] <= 1'b1;
        end
        ST_MOVE: begin
          tap[lane_q] <= (dir_q[lane_q] == DIR_INC) ? tap[lane_q] + TAP_W'(1)
                                                    : tap[lane_q] - TAP_W'(1);
          gap_cnt     <= GAP_W'(MOVE_GAP - 1);
          state       <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else if (DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
            // IOD refused the step, so the tracked tap must not count it.
            tap[lane_q] <= (dir_q[lane_q] == DIR_INC) ? tap[lane_q] - TAP_W'(1)
                                                      : tap[lane_q] + TAP_W'(1);
            state  <= ST_DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else if (tap[lane_q] == tgt_q) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            state          <= ST_MOVE;
            move_q[lane_q] <= 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          dir_q   <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dly.DLY_REQ_READY    = ready_q;
  assign dly.DLY_DONE         = done_q;
  assign dly.DLY_ERR          = err_q;
  assign DLY_TAP              = tap;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_ddr4_ca_lane_ctrl.sv
// Self-checking bench for ddr4_ca_lane_ctrl: TX latency, tap sequencing, errors and reset.
module tb_ddr4_ca_lane_ctrl;

  localparam int NL   = 2;
  localparam int SR   = 4;
  localparam int TW   = 9;
  localparam int MAXT = 255;
  localparam int INIT = 1;
  localparam int GAP  = 2;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NL*SR-1:0]  cmd_tx, cmd_oe, tx_data, oe_data;
  logic [NL*TW-1:0]  dly_tap;
  logic [NL-1:0]     dl_load, dl_move, dl_dir, oor;
`ifdef DDR4_CA_PARITY_EN
  logic [SR-1:0]     par;
`endif

  int checks = 0;
  int errors = 0;
  int model_tap[NL];

  ddr4_ca_lane_ctrl_if #(.NUM_LANES(NL), .TAP_W(TW)) dly ();

  ddr4_ca_lane_ctrl #(
    .NUM_LANES(NL), .SER_RATIO(SR), .TAP_W(TW), .MAX_TAP(MAXT),
    .INIT_TAP(INIT), .MOVE_GAP(GAP), .TX_LAT(LAT)
  ) dut (
    .FAB_CLK(clk),
    .TX_SYNC_RST(rst),
    .CMD_TX_DATA(cmd_tx),
    .CMD_OE(cmd_oe),
    .TX_DATA(tx_data),
    .OE_DATA(oe_data),
    .dly(dly),
    .DLY_TAP(dly_tap),
    .DELAY_LINE_LOAD(dl_load),
    .DELAY_LINE_MOVE(dl_move),
    .DELAY_LINE_DIRECTION(dl_dir),
    .DELAY_LINE_OUT_OF_RANGE(oor)
`ifdef DDR4_CA_PARITY_EN
    ,
    .PAR_TX_DATA(par)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic int get_tap(input int l);
    return int'(dly_tap[l*TW +: TW]);
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_data, oe_data} !== '0) begin
      errors++; $display("FAIL reset_tx got %h exp 0", {tx_data, oe_data});
    end
    checks++;
    if ({dl_load, dl_move, dl_dir, dly.DLY_DONE, dly.DLY_ERR} !== '0) begin
      errors++; $display("FAIL reset_strobes got %b exp 0", {dl_load, dl_move, dl_dir, dly.DLY_DONE, dly.DLY_ERR});
    end
    checks++;
    if (dly.DLY_REQ_READY !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", dly.DLY_REQ_READY);
    end
    for (int l = 0; l < NL; l++) begin
      checks++;
      if (get_tap(l) != INIT) begin
        errors++; $display("FAIL reset_tap lane %0d got %0d exp %0d", l, get_tap(l), INIT);
      end
      model_tap[l] = INIT;
    end
    rst = 1'b0;
  endtask

  // Data driven before edge i must show up at the outputs after edge i+LAT-1.
  task automatic test_tx_latency;
    logic [NL*SR-1:0] hd[64];
    logic [NL*SR-1:0] ho[64];
    logic [NL*SR-1:0] xd, xo;
    logic [SR-1:0]    xp;
    int               j;
    for (int i = 0; i < 30; i++) begin
      hd[i] = (i == 0) ? 8'hA5 : (i < 4) ? 8'h00 : (i == 4) ? 8'h31 : NL*SR'($urandom);
      ho[i] = (i == 0) ? 8'hA5 : (i < 4) ? 8'h00 : NL*SR'($urandom);
      cmd_tx = hd[i];
      cmd_oe = ho[i];
      @(negedge clk);
      j  = i - LAT + 1;
      xd = (j >= 0) ? hd[j] : '0;
      xo = (j >= 0) ? ho[j] : '0;
      checks++;
      if (tx_data !== xd) begin
        errors++; $display("FAIL tx_lat step %0d got %h exp %h", i, tx_data, xd);
      end
      checks++;
      if (oe_data !== xo) begin
        errors++; $display("FAIL oe_lat step %0d got %h exp %h", i, oe_data, xo);
      end
      xp = '0;
      for (int l = 0; l < NL; l++) xp ^= xd[l*SR +: SR];
`ifdef DDR4_CA_PARITY_EN
      checks++;
      if (par !== xp) begin
        errors++; $display("FAIL par_lat step %0d got %h exp %h", i, par, xp);
      end
`endif
    end
    cmd_tx = '0;
    cmd_oe = '0;
    repeat (LAT) @(negedge clk);
  endtask

  // Issue one request and check every cycle against the schedule derived from the tap rules.
  // oor_move (1-based) is the move whose GAP sees OUT_OF_RANGE; 0 means never.
  task automatic do_req(input int lane, input int t, input bit ld, input int oor_move, input string nm);
    int  e, k, nmv, m0, base, done_c, fin, mj;
    bit  rej, dir, xerr, hit;
    logic [NL-1:0] xm, xl;
    rej  = (t > MAXT);
    e    = ld ? INIT : model_tap[lane];
    base = (!rej && ld) ? 1 : 0;
    m0   = 2 + base;
    hit  = 1'b0;
    dir  = 1'b0;
    if (rej) begin
      nmv = 0; xerr = 1'b1; fin = model_tap[lane];
    end else begin
      dir = (t > e);
      k   = dir ? t - e : e - t;
      if (oor_move > 0 && oor_move <= k) begin
        nmv = oor_move; xerr = 1'b1; hit = 1'b1;
        fin = dir ? e + oor_move - 1 : e - (oor_move - 1);
      end else begin
        nmv = k; xerr = 1'b0; fin = t;
      end
    end
    done_c = (nmv == 0) ? 1 + base : m0 + nmv * (1 + GAP);
    mj     = m0 + (nmv - 1) * (1 + GAP);

    @(negedge clk);
    checks++;
    if (dly.DLY_REQ_READY !== 1'b1) begin
      errors++; $display("FAIL %s ready_idle got %b exp 1", nm, dly.DLY_REQ_READY);
    end
    dly.DLY_REQ_VALID = 1'b1;
    dly.DLY_REQ_LANE  = 1'(lane);
    dly.DLY_REQ_TAP   = TW'(t);
    dly.DLY_REQ_LOAD  = ld;
    @(posedge clk);
    #1;
    dly.DLY_REQ_VALID = 1'b0;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      oor = (hit && c > mj && c <= mj + GAP) ? (NL'(1) << lane) : '0;
      xm  = (c >= m0 && (c - m0) % (1 + GAP) == 0 && (c - m0) / (1 + GAP) < nmv) ? (NL'(1) << lane) : '0;
      xl  = (!rej && ld && c == 1) ? (NL'(1) << lane) : '0;
      checks++;
      if (dl_move !== xm) begin
        errors++; $display("FAIL %s move c%0d got %b exp %b", nm, c, dl_move, xm);
      end
      checks++;
      if (dl_load !== xl) begin
        errors++; $display("FAIL %s load c%0d got %b exp %b", nm, c, dl_load, xl);
      end
      checks++;
      if (dly.DLY_DONE !== (c == done_c)) begin
        errors++; $display("FAIL %s done c%0d got %b exp %b", nm, c, dly.DLY_DONE, (c == done_c));
      end
      if (c == done_c) begin
        checks++;
        if (dly.DLY_ERR !== xerr) begin
          errors++; $display("FAIL %s err got %b exp %b", nm, dly.DLY_ERR, xerr);
        end
      end
      if (xm != '0) begin
        checks++;
        if (dl_dir !== (NL'(dir) << lane)) begin
          errors++; $display("FAIL %s dir c%0d got %b exp %b", nm, c, dl_dir, NL'(dir) << lane);
        end
      end
      checks++;
      if (dly.DLY_REQ_READY !== (c == done_c + 1)) begin
        errors++; $display("FAIL %s ready c%0d got %b exp %b", nm, c, dly.DLY_REQ_READY, (c == done_c + 1));
      end
    end
    oor = '0;
    model_tap[lane] = fin;
    for (int l = 0; l < NL; l++) begin
      checks++;
      if (get_tap(l) != model_tap[l]) begin
        errors++; $display("FAIL %s tap lane %0d got %0d exp %0d", nm, l, get_tap(l), model_tap[l]);
      end
    end
  endtask

  task automatic test_step_up;
    do_req(1, 4, 1'b0, 0, "step_up");
  endtask

  task automatic test_load_down;
    do_req(0, 10, 1'b0, 0, "set10");
    do_req(0, 0, 1'b1, 0, "load_down");
  endtask

  task automatic test_out_of_range;
    do_req(0, 5, 1'b0, 2, "oor_up");
    do_req(1, 1, 1'b0, 1, "oor_down_first");
  endtask

  task automatic test_reject;
    do_req(1, 300, 1'b0, 0, "reject");
    do_req(0, 256, 1'b1, 0, "reject_load");
  endtask

  task automatic test_zero_step;
    do_req(1, model_tap[1], 1'b0, 0, "zero_step");
    do_req(0, INIT, 1'b1, 0, "load_only");
  endtask

  task automatic test_random;
    int lane, t, oorm;
    bit ld;
    for (int n = 0; n < 14; n++) begin
      lane = int'($urandom_range(0, NL - 1));
      ld   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        t = int'($urandom_range(MAXT + 1, 511));
      end else begin
        t = model_tap[lane] + int'($urandom_range(0, 12)) - 6;
        if (t < 0) t = 0;
      end
      oorm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_req(lane, t, ld, oorm, "random");
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    dly.DLY_REQ_VALID = 1'b1;
    dly.DLY_REQ_LANE  = 1'b1;
    dly.DLY_REQ_TAP   = TW'(model_tap[1] + 8);
    dly.DLY_REQ_LOAD  = 1'b0;
    @(posedge clk);
    #1;
    dly.DLY_REQ_VALID = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dl_move !== 2'b10) begin
      errors++; $display("FAIL rst_mid move_before got %b exp 10", dl_move);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dl_load, dl_move, dl_dir, dly.DLY_DONE} !== '0) begin
      errors++; $display("FAIL rst_mid strobes got %b exp 0", {dl_load, dl_move, dl_dir, dly.DLY_DONE});
    end
    checks++;
    if (dly.DLY_REQ_READY !== 1'b1) begin
      errors++; $display("FAIL rst_mid ready got %b exp 1", dly.DLY_REQ_READY);
    end
    for (int l = 0; l < NL; l++) begin
      checks++;
      if (get_tap(l) != INIT) begin
        errors++; $display("FAIL rst_mid tap lane %0d got %0d exp %0d", l, get_tap(l), INIT);
      end
      model_tap[l] = INIT;
    end
    rst = 1'b0;
    do_req(1, 3, 1'b1, 0, "post_rst_load");
  endtask

  initial begin
    rst               = 1'b1;
    cmd_tx            = '0;
    cmd_oe            = '0;
    oor               = '0;
    dly.DLY_REQ_VALID = 1'b0;
    dly.DLY_REQ_LANE  = '0;
    dly.DLY_REQ_TAP   = '0;
    dly.DLY_REQ_LOAD  = 1'b0;
    test_reset;
    test_tx_latency;
    test_step_up;
    test_load_down;
    test_out_of_range;
    test_reject;
    test_zero_step;
    test_random;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
